// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS panel path: power FSM states, default panel timing, totals.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lvds_pkg;

  // Power sequencing states, in power-up order followed by the reverse path.
  typedef enum logic [2:0] {
    OFF     = 3'd0,
    VDD_UP  = 3'd1,
    LINK_UP = 3'd2,
    RUN     = 3'd3,
    LINK_DN = 3'd4,
    VDD_DN  = 3'd5,
    COOL    = 3'd6
  } panelState_t;

  // Default timing for the 1366x768 laptop panel.
  localparam int DEF_H_ACTIVE   = 1366;
  localparam int DEF_H_FRONT    = 48;
  localparam int DEF_H_SYNC     = 32;
  localparam int DEF_H_BACK     = 146;
  localparam int DEF_V_ACTIVE   = 768;
  localparam int DEF_V_FRONT    = 3;
  localparam int DEF_V_SYNC     = 6;
  localparam int DEF_V_BACK     = 29;
  localparam int DEF_T_VDD_LVDS = 2_000_000;
  localparam int DEF_T_LVDS_BL  = 10_000_000;
  localparam int DEF_T_OFF_MIN  = 25_000_000;
  localparam int DEF_CW         = 11;
  localparam int DEF_TW         = 25;

  // Full period of a line (in clocks) or a frame (in lines).
  function automatic int periodTotal(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/lvds_video_timing.sv
// Video timing generator: h/v counters with registered hsync/vsync/de/frameStart/pixel coordinates.
// Latency: outputs show pixel (0,0) on the same edge that run first samples high; all outputs aligned.
// Backpressure: none; free-running while run=1, held at 0 while run=0.
module lvds_video_timing
  import lvds_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int CW       = DEF_CW
) (
  input  logic          pllInClock,
  input  logic          reset,
  input  logic          run,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frameStart,
  output logic [CW-1:0] pixelX,
  output logic [CW-1:0] pixelY
);

  localparam int H_TOT = periodTotal(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOT = periodTotal(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  // hCount/vCount always hold the pixel currently presented on the outputs.
  logic [CW-1:0] hCount, vCount;
  logic [CW-1:0] hNext, vNext;
  logic          running;
  logic          deNext, hsNext, vsNext, fsNext;

  // Advance to the next pixel; the first running cycle presents (0,0) rather than advancing.
  always_comb begin
    hNext  = '0;
    vNext  = '0;
    if (run && running) begin
      if (hCount == CW'(H_TOT - 1)) begin
        hNext = '0;
        vNext = (vCount == CW'(V_TOT - 1)) ? '0 : vCount + 1'b1;
      end else begin
        hNext = hCount + 1'b1;
        vNext = vCount;
      end
    end
    deNext = run && (hNext < CW'(H_ACTIVE)) && (vNext < CW'(V_ACTIVE));
    hsNext = run && (hNext >= CW'(H_ACTIVE + H_FRONT)) && (hNext < CW'(H_ACTIVE + H_FRONT + H_SYNC));
    vsNext = run && (vNext >= CW'(V_ACTIVE + V_FRONT)) && (vNext < CW'(V_ACTIVE + V_FRONT + V_SYNC));
    fsNext = run && (hNext == '0) && (vNext == '0);
  end

  // Register counters and decoded outputs together so everything stays mutually aligned.
  always_ff @(posedge pllInClock or posedge reset) begin
    if (reset) begin
      running    <= 1'b0;
      hCount     <= '0;
      vCount     <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      de         <= 1'b0;
      frameStart <= 1'b0;
      pixelX     <= '0;
      pixelY     <= '0;
    end else begin
      running    <= run;
      hCount     <= hNext;
      vCount     <= vNext;
      hsync      <= hsNext;
      vsync      <= vsNext;
      de         <= deNext;
      frameStart <= fsNext;
      pixelX     <= deNext ? hNext : '0;
      pixelY     <= deNext ? vNext : '0;
    end
  end

endmodule

// File: rtl/lvds_panel_sequencer.sv
// LVDS panel controller: VDD -> link -> backlight power sequencing plus video timing generation.
// Latency: panelEn to first enable change is 3 clocks (2-FF sync + registered FSM output).
// Backpressure: none; panelEn is a level request, honoured only at legal sequencing points.
module lvds_panel_sequencer
  import lvds_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int T_VDD_LVDS = DEF_T_VDD_LVDS,
  parameter int T_LVDS_BL  = DEF_T_LVDS_BL,
  parameter int T_OFF_MIN  = DEF_T_OFF_MIN,
  parameter int CW         = DEF_CW,
  parameter int TW         = DEF_TW
) (
  input  logic          pllInClock,
  input  logic          reset,
  input  logic          panelEn,
  output logic          panelVdd,
  output logic          lvdsEn,
  output logic          backlightEn,
  output logic          panelReady,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frameStart,
  output logic [CW-1:0] pixelX,
  output logic [CW-1:0] pixelY
);

  logic [1:0]    enSync;
  logic          panelEnS;
  panelState_t   state, nextState;
  logic [TW-1:0] timer, timerNext;
  logic          vddNext, lvdsNext, blNext, readyNext;

  // Each state's dwell is timer reload + 1 clocks, since the exit is taken on the cycle timer==0.
  function automatic logic [TW-1:0] reloadFor(input panelState_t s);
    case (s)
      VDD_UP, VDD_DN:   reloadFor = TW'(T_VDD_LVDS - 1);
      LINK_UP, LINK_DN: reloadFor = TW'(T_LVDS_BL - 1);
      COOL:             reloadFor = TW'(T_OFF_MIN - 1);
      default:          reloadFor = '0;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous MCU request.
  always_ff @(posedge pllInClock or posedge reset) begin
    if (reset) enSync <= '0;
    else       enSync <= {enSync[0], panelEn};
  end
  assign panelEnS = enSync[1];

  // Next state, timer and enable decode; aborts always fall back onto the reverse path.
  always_comb begin
    nextState = state;
    case (state)
      OFF:     if (panelEnS) nextState = VDD_UP;
      VDD_UP:  if (!panelEnS) nextState = VDD_DN;
               else if (timer == '0) nextState = LINK_UP;
      LINK_UP: if (!panelEnS) nextState = LINK_DN;
               else if (timer == '0) nextState = RUN;
      RUN:     if (!panelEnS) nextState = LINK_DN;
      LINK_DN: if (timer == '0) nextState = VDD_DN;
      VDD_DN:  if (timer == '0) nextState = COOL;
      COOL:    if (timer == '0) nextState = OFF;
      default: nextState = OFF;
    endcase

    if (nextState != state)  timerNext = reloadFor(nextState);
    else if (timer != '0)    timerNext = timer - 1'b1;
    else                     timerNext = timer;

    vddNext   = nextState inside {VDD_UP, LINK_UP, RUN, LINK_DN, VDD_DN};
    lvdsNext  = nextState inside {LINK_UP, RUN, LINK_DN};
    blNext    = (nextState == RUN);
    readyNext = (nextState == RUN);
  end

  // State, timer and registered enables.
  always_ff @(posedge pllInClock or posedge reset) begin
    if (reset) begin
      state       <= OFF;
      timer       <= '0;
      panelVdd    <= 1'b0;
      lvdsEn      <= 1'b0;
      backlightEn <= 1'b0;
      panelReady  <= 1'b0;
    end else begin
      state       <= nextState;
      timer       <= timerNext;
      panelVdd    <= vddNext;
      lvdsEn      <= lvdsNext;
      backlightEn <= blNext;
      panelReady  <= readyNext;
    end
  end

  // Driven from the D side of lvdsEn so timing outputs start and stop on the same edge as lvdsEn.
  lvds_video_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .CW       (CW)
  ) uTiming (
    .pllInClock (pllInClock),
    .reset      (reset),
    .run        (lvdsNext),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frameStart (frameStart),
    .pixelX     (pixelX),
    .pixelY     (pixelY)
  );

endmodule
